// File: rtl/rnn_pkg.sv
// Shared definitions for the RNN core and its hidden-state capture stage.
package rnn_pkg;

    // Hidden-state word width (Q4.16 signed) and words per frame
    localparam int DW    = 20;
    localparam int HID   = 64;
    localparam int STEPW = 16;
    localparam int AW    = $clog2(HID);
    localparam int CW    = AW + 1;

    // Core memory bank selects
    localparam logic [2:0] MSEL_WIH  = 3'b000;
    localparam logic [2:0] MSEL_BIH  = 3'b001;
    localparam logic [2:0] MSEL_WHH  = 3'b010;
    localparam logic [2:0] MSEL_BHH  = 3'b011;
    localparam logic [2:0] MSEL_IN   = 3'b100;
    localparam logic [2:0] MSEL_HOUT = 3'b101;

    typedef logic signed [DW-1:0] hword_t;

    typedef enum logic {
        RD_IDLE   = 1'b0,
        RD_STREAM = 1'b1
    } rd_state_e;

    // A core write that lands on the hidden-state output bank
    function automatic logic is_hout_strobe(input logic mce, input logic [2:0] msel);
        return mce && (msel == MSEL_HOUT);
    endfunction

endpackage

// File: rtl/rnn_frame_buf.sv
// One frame of hidden-state storage: write port, capture count,
// ready-to-read flag, combinational read port and a free strobe.
module rnn_frame_buf
    import rnn_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  hword_t        wdata_i,
    input  logic [AW-1:0] raddr_i,
    output hword_t        rdata_o,
    input  logic          free_i,
    output logic          ready_o,
    output logic          full_o
);

    hword_t        mem_q [HID];
    logic [CW-1:0] count_q, count_d;
    logic          ready_q, ready_d;
    logic          wr_en;

    // A buffer holding an unread frame refuses writes; the top counts those as drops.
    assign wr_en   = we_i && !ready_q && !clr_i;
    assign rdata_o = mem_q[raddr_i];
    assign ready_o = ready_q;

    // Word storage write port
    // NOTE: the storage array is deliberately not reset; ready_q guards every read,
    // so stale contents are never presented and the array can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Capture count and ready flag next-state; flush and free both empty the buffer
    always_comb begin
        // NOTE: every output of this block is given a default first so no path
        // leaves a variable unassigned, which would otherwise infer a latch.
        count_d = count_q;
        ready_d = ready_q;
        full_o  = 1'b0;
        if (clr_i || free_i) begin
            count_d = '0;
            ready_d = 1'b0;
        end else if (wr_en) begin
            count_d = count_q + CW'(1);
            if (count_d == CW'(HID)) begin
                ready_d = 1'b1;
                full_o  = 1'b1;
            end
        end
    end

    // Count and flag registers
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state registers use non-blocking assignment so every flop samples
        // the pre-edge values regardless of block ordering.
        if (!reset) begin
            count_q <= '0;
            ready_q <= 1'b0;
        end else begin
            count_q <= count_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: rtl/rnn_h_collector.sv
// Hidden-state capture stage: snoops core writes to the output bank,
// assembles 64-word frames into two ping-pong buffers and streams them
// out over valid/ready. Frames that find no free buffer are dropped and
// flagged on the sticky ovf output, since the core cannot be stalled.
module rnn_h_collector
    import rnn_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             mce,
    input  logic [2:0]       msel,
    input  logic [16:0]      maddr,
    input  logic [DW-1:0]    mdata_w,
    input  logic             clr,
    output logic             o_valid,
    input  logic             o_ready,
    output logic [DW-1:0]    o_data,
    output logic [AW-1:0]    o_addr,
    output logic             o_last,
    output logic [STEPW-1:0] o_step,
    output logic             ovf
);

    rd_state_e        state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic             rsel_q, rsel_d;
    logic             wsel_q, wsel_d;
    logic [STEPW-1:0] step_q, step_d;
    logic             ovf_q, ovf_d;

    logic             strobe;
    logic             last_hs;
    logic [1:0]       we, free, ready, full;
    hword_t           rdata [2];
    logic             unused_maddr;

    // Only the word index within the frame matters; upper address bits are don't-care.
    assign unused_maddr = ^maddr[16:AW];

    // A capture in the same cycle as a flush is discarded.
    assign strobe = is_hout_strobe(mce, msel) && !clr;

    for (genvar b = 0; b < 2; b++) begin : g_buf
        assign we[b]   = strobe && (wsel_q == 1'(b));
        assign free[b] = last_hs && (rsel_q == 1'(b));

        rnn_frame_buf u_buf (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (clr),
            .we_i    (we[b]),
            .waddr_i (maddr[AW-1:0]),
            .wdata_i (mdata_w),
            .raddr_i (idx_q),
            .rdata_o (rdata[b]),
            .free_i  (free[b]),
            .ready_o (ready[b]),
            .full_o  (full[b])
        );
    end

    // Write-side next-state: buffer toggle on a completed frame, sticky drop flag
    always_comb begin
        wsel_d = wsel_q;
        ovf_d  = ovf_q;
        if (clr) begin
            wsel_d = 1'b0;
            ovf_d  = 1'b0;
        end else begin
            if (full[wsel_q]) begin
                wsel_d = ~wsel_q;
            end
            if (strobe && ready[wsel_q]) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Write-side registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wsel_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            wsel_q <= wsel_d;
            ovf_q  <= ovf_d;
        end
    end

    // Read FSM next-state: walk the ready buffer in ascending order, then hand it back
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rsel_d  = rsel_q;
        step_d  = step_q;
        last_hs = 1'b0;
        if (clr) begin
            state_d = RD_IDLE;
            idx_d   = '0;
            rsel_d  = 1'b0;
            step_d  = '0;
        end else begin
            case (state_q)
                RD_IDLE: begin
                    if (ready[rsel_q]) begin
                        state_d = RD_STREAM;
                        idx_d   = '0;
                    end
                end
                RD_STREAM: begin
                    if (o_ready) begin
                        if (idx_q == AW'(HID - 1)) begin
                            last_hs = 1'b1;
                            idx_d   = '0;
                            rsel_d  = ~rsel_q;
                            step_d  = step_q + STEPW'(1);
                            // Chain straight into the other frame when it is already waiting
                            state_d = ready[~rsel_q] ? RD_STREAM : RD_IDLE;
                        end else begin
                            idx_d = idx_q + AW'(1);
                        end
                    end
                end
                default: state_d = RD_IDLE;
            endcase
        end
    end

    // Read FSM registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RD_IDLE;
            idx_q   <= '0;
            rsel_q  <= 1'b0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rsel_q  <= rsel_d;
            step_q  <= step_d;
        end
    end

    // Outputs come straight from registers and the selected buffer, so they hold during a stall.
    assign o_valid = (state_q == RD_STREAM);
    assign o_data  = o_valid ? rdata[rsel_q] : '0;
    assign o_addr  = idx_q;
    assign o_last  = o_valid && (idx_q == AW'(HID - 1));
    assign o_step  = step_q;
    assign ovf     = ovf_q;

endmodule

// File: doc/rnn_h_collector.md
# rnn_h_collector

Downstream capture stage for the RNN core's hidden-state output. Snoops the core's memory write port, catches every hidden-state word written on the output bank, and assembles the words into 64-word frames, one per time step. Double-buffers the frames and streams them out over a valid/ready interface. Dropped frames are flagged rather than back-pressuring the core, because the core has no stall input.

## Interface
- DW, 20, hidden-state word width (Q4.16 signed)
- HID, 64, words per frame (hidden size)
- STEPW, 16, width of time-step counter
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- mce  in  1  core memory enable
- msel  in  3  core bank select; capture bank is 3'b101
- maddr  in  17  core address; only [5:0] used
- mdata_w  in  DW  core write data
- clr  in  1  synchronous flush, highest priority after reset
- o_valid  out  1  output word valid
- o_ready  in  1  consumer accepts word
- o_data  out  DW  hidden-state word
- o_addr  out  6  index of o_data within frame
- o_last  out  1  high with index HID-1
- o_step  out  STEPW  time-step number of current frame
- ovf  out  1  sticky: at least one capture dropped

## Operation
- Capture strobe: mce==1 && msel==3'b101. Word stored at buf[wsel][maddr[5:0]]. maddr[16:6] ignored.
- Each buffer has a 7-bit capture count. A buffer is full when its count reaches HID.
  - Every strobe counts, including repeated addresses.
  - On full, the buffer is marked ready-to-read and wsel toggles.
- Writable buffer: empty (count 0, not ready-to-read). If the target buffer is not writable, the strobe is dropped, ovf is set, and the count is unchanged.
- Read FSM, IDLE: if buf[rsel] is ready-to-read, go to STREAM with idx=0.
- Read FSM, STREAM:
  - Present buf[rsel][idx] on o_data with o_addr=idx and o_valid=1.
  - On handshake (o_valid && o_ready), idx increments.
  - On the handshake with idx==HID-1 (o_last=1):
    - buf[rsel] is emptied and rsel toggles.
    - o_step increments, wrapping at 2^STEPW.
    - Next state is STREAM if the other buffer is ready, else IDLE.
- Output words appear in ascending address order regardless of the order the core wrote them.
- Outputs are stable while o_valid && !o_ready.
- clr: both buffers emptied, wsel=rsel=0, idx=0, o_step=0, ovf=0, o_valid=0, FSM to IDLE. A capture strobe in the same cycle as clr is discarded.

## Timing
- Reset values: o_valid=0, o_data=0, o_addr=0, o_last=0, o_step=0, ovf=0, FSM IDLE, wsel=rsel=0.
- Capture latency: the 64th strobe at edge N marks the buffer full at edge N. o_valid rises after edge N+1, since the FSM is registered.
- Throughput: one word per cycle while o_ready is held high. Frames stream back-to-back with no bubble when the next buffer is already ready.
- Buffer freed at edge N (last handshake) is writable for strobes sampled at edge N+1. A strobe at edge N aimed at that buffer is dropped and sets ovf.
- Full and free in the same cycle: both take effect; wsel and rsel update independently.
- reset low mid-frame: immediate asynchronous clear. A partial frame is lost and ovf is not set.
- clr mid-stream: o_valid low after the next edge, with no o_last emitted.

## Structure
- Shared package rnn_pkg:
  - MSEL_WIH=3'b000, MSEL_BIH=3'b001, MSEL_WHH=3'b010, MSEL_BHH=3'b011, MSEL_IN=3'b100, MSEL_HOUT=3'b101
  - DW, HID
  - typedef of the signed hidden word
- Sub-module rnn_frame_buf: one HID×DW storage with capture count, full/ready flag, write port, combinational read port and free input. Instantiated twice. The top holds wsel/rsel, the read FSM, o_step and ovf.

## Test plan
- Frame capture: 64 strobes with maddr 63..0, data = 0x100*addr; o_ready=1 → 64 words with o_addr 0..63, o_data=0x100*o_addr, o_last only on word 63, o_step=0.
- Back-to-back: two frames fed with no gap, o_ready=1 → 128 consecutive valid words; o_step=0 then 1; no bubble at the frame boundary.
- Back-pressure: o_ready toggling 1/0 every cycle → each word held stable while o_ready=0; 64 words total; data matches.
- Overflow: o_ready=0, feed three frames → first two retained, all third-frame strobes dropped, ovf=1. Releasing o_ready then yields exactly 128 words.
- Ignored traffic: strobes with msel=3'b011, and mce=0 with msel=3'b101 → nothing captured, o_valid stays 0.
- Resets: clr asserted at word 10 of streaming → o_valid=0 next cycle, o_step=0, ovf=0. reset pulled low asynchronously mid-capture → all outputs at reset values before the next edge.
